// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage.
//   XLEN        : datapath and address width (only 32 is supported)
//   F3_*        : funct3 width/sign codes for loads and stores
//   mem_state_t : memory-access FSM states
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load-data formatter: picks the addressed byte or halfword out of a
// naturally aligned memory word and sign- or zero-extends it.
// Ports:
//   rdata   in  XLEN  raw word returned by data memory
//   addr_lo in  2     low address bits selecting the byte/half lane
//   funct3  in  3     load width/sign code (LB, LH, LW, LBU, LHU)
//   data    out XLEN  formatted load result
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    // Halfword accesses are already known to be aligned, so only bit 1 matters.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues loads/stores on a req/ready/rvalid data-memory port, builds byte
// enables and lane-replicated store data, formats load data, stalls the
// upstream pipeline for the duration of an access and aborts accesses that
// exceed TIMEOUT cycles waiting for the memory.
// Ports:
//   clk, reset (sync, active-low)
//   *_EX          : instruction from the EX/MEM register
//   dmem_*        : data-memory request/response port
//   stall_MEM     : freeze PC, IF/ID, ID/EX and EX/MEM
//   regwrite_MEM, rd_MEM, rd_data_MEM : write-back info into MEM/WB
//   misalign_MEM  : one-cycle pulse for a misaligned or illegal access
//   buserr_MEM    : one-cycle pulse for a timed-out access
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_EX,
  input  logic            memread_EX,
  input  logic            memwrite_EX,
  input  logic [2:0]      funct3_EX,
  input  logic            regwrite_EX,
  input  logic [4:0]      rd_EX,
  input  logic [XLEN-1:0] alu_result_EX,
  input  logic [XLEN-1:0] rs2_data_EX,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_MEM,
  output logic            regwrite_MEM,
  output logic [4:0]      rd_MEM,
  output logic [XLEN-1:0] rd_data_MEM,
  output logic            misalign_MEM,
  output logic            buserr_MEM
);

  import riscv_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] ldata_q, ldata_d;

  logic            is_mem;
  logic            misaligned;
  logic            illegal;
  logic            access_ok;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] load_fmt;
  logic            timeout;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_fmt)
  );

  // Decode of the incoming EX/MEM instruction: alignment, legality, byte
  // enables and store-lane replication.
  always_comb begin
    is_mem     = memread_EX | memwrite_EX;
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = rs2_data_EX;
    case (funct3_EX[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result_EX[1:0];
        wdata_new = {4{rs2_data_EX[7:0]}};
      end
      2'b01: begin
        misaligned = alu_result_EX[0];
        be_new     = 4'b0011 << alu_result_EX[1:0];
        wdata_new  = {2{rs2_data_EX[15:0]}};
      end
      2'b10: misaligned = |alu_result_EX[1:0];
      default: misaligned = 1'b0;
    endcase
    // Stores have no unsigned forms; loads additionally reject 110.
    illegal   = (funct3_EX[1:0] == 2'b11) |
                (memwrite_EX ? funct3_EX[2] : (funct3_EX[2] & funct3_EX[1]));
    access_ok = valid_EX & is_mem & ~misaligned & ~illegal;
  end

  // Timeout counts the total wait across REQ and RESP; using >= keeps the
  // abort firing even if the counter has passed the limit on entering RESP.
  assign timeout = (cnt_q >= CW'(TIMEOUT - 1));

  // Next-state, hold-register updates and all stage outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ldata_d = ldata_q;

    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_be      = 4'b0000;
    stall_MEM    = 1'b0;
    regwrite_MEM = 1'b0;
    rd_MEM       = 5'd0;
    rd_data_MEM  = '0;
    misalign_MEM = 1'b0;
    buserr_MEM   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_EX) begin
          if (!is_mem) begin
            regwrite_MEM = regwrite_EX;
            rd_MEM       = rd_EX;
            rd_data_MEM  = alu_result_EX;
          end else if (access_ok) begin
            we_d      = memwrite_EX;
            f3_d      = funct3_EX;
            addr_d    = alu_result_EX;
            rd_d      = rd_EX;
            rw_d      = regwrite_EX;
            wdata_d   = wdata_new;
            be_d      = be_new;
            ldata_d   = '0;
            cnt_d     = '0;
            stall_MEM = 1'b1;
            state_d   = REQ;
          end else begin
            misalign_MEM = 1'b1;
          end
        end
      end

      REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        dmem_wdata = wdata_q;
        dmem_be    = be_q;
        stall_MEM  = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (dmem_ready) begin
          state_d = we_q ? DONE : RESP;
        end else if (timeout) begin
          buserr_MEM = 1'b1;
          rw_d       = 1'b0;
          ldata_d    = '0;
          state_d    = DONE;
        end
      end

      RESP: begin
        stall_MEM = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (dmem_rvalid) begin
          ldata_d = load_fmt;
          state_d = DONE;
        end else if (timeout) begin
          buserr_MEM = 1'b1;
          rw_d       = 1'b0;
          ldata_d    = '0;
          state_d    = DONE;
        end
      end

      DONE: begin
        regwrite_MEM = rw_q & ~we_q;
        rd_MEM       = rd_q;
        rd_data_MEM  = we_q ? '0 : ldata_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Reset silences the stage immediately, including a request in flight.
    if (!reset) begin
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = '0;
      dmem_wdata   = '0;
      dmem_be      = 4'b0000;
      stall_MEM    = 1'b0;
      regwrite_MEM = 1'b0;
      rd_MEM       = 5'd0;
      rd_data_MEM  = '0;
      misalign_MEM = 1'b0;
      buserr_MEM   = 1'b0;
    end
  end

  // State, timeout counter and access hold registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ldata_q <= ldata_d;
    end
  end

endmodule
